// File: rtl/alu_issue_stage_if.sv
// Handshake bundle between the ALU issue stage and its neighbours: instruction intake on the
// in_* side, issued ALU operands on the out_* side.
interface alu_issue_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_op1;
    logic [XLEN-1:0] out_op2;
    logic [3:0]      out_op_code;
    logic [4:0]      out_rd;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
        output in_ready, out_valid, out_op1, out_op2, out_op_code, out_rd, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
        input  in_ready, out_valid, out_op1, out_op2, out_op_code, out_rd, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I ALU-class decode/issue stage: decodes OP, OP-IMM, LUI and AUIPC into ALU operands and
// op_code, presented through a 2-entry skid buffer (main register M, overflow register S).
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_stage_if.slave  bus
);
    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_XOR  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_ADD  = 4'b0100,
        ALU_SUB  = 4'b0101,
        ALU_SLL  = 4'b0110,
        ALU_SRL  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_PASS = 4'b1111
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        alu_op_e         op_code;
        logic [4:0]      rd;
        logic            illegal;
    } entry_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // ALU_PASS doubles as the "not executable" marker (SRA/SRAI land here).
    function automatic alu_op_e funct3_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_PASS : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    entry_t          dec;

    assign opcode = bus.in_instr[6:0];
    assign funct3 = bus.in_instr[14:12];
    assign imm_i  = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
    assign imm_u  = {bus.in_instr[31:12], 12'b0};

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves dec unassigned,
        // which would otherwise infer a latch.
        dec.op1     = bus.in_rs1_data;
        dec.op2     = '0;
        dec.op_code = ALU_PASS;
        dec.rd      = bus.in_instr[11:7];
        dec.illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.op_code = funct3_op(funct3, bus.in_instr[30]);
                dec.op2     = bus.in_rs2_data;
            end
            OPC_OP_IMM: begin
                // Bit 30 is immediate data for ADDI, so it only selects a variant on shifts.
                dec.op_code = funct3_op(funct3, (funct3 != 3'b000) && bus.in_instr[30]);
                dec.op2     = imm_i;
            end
            OPC_LUI: begin
                dec.op_code = ALU_ADD;
                dec.op1     = '0;
                dec.op2     = imm_u;
            end
            OPC_AUIPC: begin
                dec.op_code = ALU_ADD;
                dec.op1     = bus.in_pc;
                dec.op2     = imm_u;
            end
            default: ;
        endcase
        if (dec.op_code == ALU_PASS) begin
            dec.illegal = 1'b1;
            dec.op1     = bus.in_rs1_data;
            dec.op2     = '0;
        end
    end

    entry_t m_ent;
    entry_t s_ent;
    logic   m_valid;
    logic   s_valid;
    logic   accept;
    logic   drain;

    // in_ready comes straight from the skid flag, keeping out_ready off the input path.
    assign bus.in_ready = !s_valid;
    assign accept       = bus.in_valid && !s_valid;
    assign drain        = m_valid && bus.out_ready;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the payload registers are reset too, because the outputs must read zero
            // after reset and not just be flagged invalid.
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_ent   <= '0;
            s_ent   <= '0;
        end else if (drain) begin
            if (s_valid) begin
                m_ent   <= s_ent;
                s_valid <= 1'b0;
            end else if (accept) begin
                m_ent <= dec;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (!m_valid) begin
            if (accept) begin
                m_ent   <= dec;
                m_valid <= 1'b1;
            end
        end else if (accept) begin
            s_ent   <= dec;
            s_valid <= 1'b1;
        end
    end

    assign bus.out_valid   = m_valid;
    assign bus.out_op1     = m_ent.op1;
    assign bus.out_op2     = m_ent.op2;
    assign bus.out_op_code = m_ent.op_code;
    assign bus.out_rd      = m_ent.rd;
    assign bus.out_illegal = m_ent.illegal;
endmodule
